red_pitaya_asg_sweep: RTL and testbench
=======================================

# red_pitaya_asg_sweep

Frequency-sweep generator feeding the ASG channel's phase-step inputs. After a trigger it moves a 64-bit step word from a start value to a stop value in linear (optionally geometric) increments at a programmable update period. It supports single, sawtooth-repeat and triangle sweep modes. `step_o[63:32]` drives the channel's `set_step_i` and `step_o[31:0]` drives its `set_step_lo_i`; the channel latches both on its own trigger.

## Interface
- `STEP_W`, 64: step word width; the hi/lo split is fixed at 32/32.
- `TICK_W`, 32: update-period counter width.
- `dac_clk_i` in 1: DAC clock (125 MHz).
- `dac_rst_i` in 1: reset, synchronous, active-high.
- `trig_i` in 1: start pulse; wired to the ASG channel trigger notification.
- `set_en_i` in 1: sweep enable; low forces IDLE.
- `set_rst_i` in 1: soft reset to IDLE; has priority over everything except `dac_rst_i`.
- `set_start_i` in STEP_W: start step.
- `set_stop_i` in STEP_W: stop step.
- `set_delta_i` in STEP_W: linear increment.
- `set_period_i` in TICK_W: clocks between updates; 0 is treated as 1.
- `set_mode_i` in 2: sweep mode; 0 single, 1 sawtooth repeat, 2 triangle repeat, 3 triangle single.
- `set_log_i` in 1: geometric sweep select.
- `set_log_shift_i` in 6: geometric ratio 2^-shift.
- `step_o` out STEP_W: current step word.
- `step_vld_o` out 1: one-cycle pulse when `step_o` changes.
- `busy_o` out 1: high while sweeping.
- `done_o` out 1: one-cycle pulse at the end of each completed sweep.
- `sweep_cnt_o` out 32: count of completed sweeps; wraps at 2^32.

## Operation
- **Direction:** up if the latched start < stop, else down.
- **Latching:** all `set_*` values except `set_en_i`/`set_rst_i` are latched on the accepted trigger and are stable for the whole sweep.
- **FSM states:** IDLE, ARMED, FWD, REV, DONE.
  - IDLE → ARMED when `set_en_i`=1; `step_o` <= `set_start_i`.
  - ARMED → FWD on `trig_i`.
  - FWD end-of-leg, by mode:
    - mode 0: → DONE.
    - mode 1: `step_o` <= start, stay in FWD.
    - modes 2/3: → REV.
  - REV end-of-leg: mode 2 → FWD; mode 3 → DONE.
  - DONE holds `step_o` until `set_en_i`=0 or `set_rst_i`, then → IDLE.
- **Sweep completion:** a sweep is complete at each sawtooth wrap, at the end of each triangle REV leg, and on entry to DONE. Each completion pulses `done_o` and increments `sweep_cnt_o`.
- **Linear update (FWD, up):** nxt = cur + delta, computed 65 bits wide. If there is a carry or nxt ≥ stop, `step_o` <= stop and the leg ends. Down direction and REV use subtraction, clamp at the leg target on borrow, and compare ≤.
- **Geometric update:** inc = cur >> shift; if inc = 0, inc = 1. The same clamp rules as linear apply.
- **Degenerate settings:**
  - start == stop: the first tick ends the leg, and `step_o` stays at start.
  - delta = 0 (linear): `step_o` never changes, `busy_o` stays high, and no `done_o` is produced.
- **Ignored inputs:** `trig_i` in FWD/REV/DONE is ignored.
- **Disable:** `set_en_i`=0 in any state → IDLE; `step_o` holds its current value and `busy_o`=0.
- **Priority:** if `set_rst_i` and `trig_i` arrive in the same cycle, the state goes to IDLE, `step_o` <= `set_start_i`, and the trigger is dropped.

## Timing
- **Reset values:** `step_o`=0, `step_vld_o`=0, `busy_o`=0, `done_o`=0, `sweep_cnt_o`=0, state IDLE, tick counter 0.
- **Trigger accept:** `trig_i` in cycle n puts the FSM in FWD at n+1, with `busy_o`=1 from n+1.
- **Update cadence:** the tick counter loads period-1 at n+1. The first update of `step_o` is visible at n+1+period, and subsequent updates follow every period clocks.
- **Pulse alignment:** `step_vld_o` and `done_o` are registered and aligned with the `step_o` change they describe. `busy_o` falls in the same cycle DONE is entered.
- **Reversal:** the direction change takes effect on the next tick, so the stop value is held for exactly one period.
- **Throughput:** one update per tick, so period=1 gives a new step every clock.

## Configuration
- Macro: `ASG_SWEEP_LOG_EN`.
- **Defined:** the geometric path, the barrel shifter and `set_log_shift_i` are active.
- **Undefined:** `set_log_i` and `set_log_shift_i` are ignored, only the linear adder is built, and the sweep is always linear.

## Structure
- **Package `asg_sweep_pkg`:**
  - FSM state enum (`SWP_IDLE`/`ARMED`/`FWD`/`REV`/`DONE`);
  - mode encodings `SWP_SINGLE`/`SAW`/`TRI`/`TRI_ONCE`;
  - `STEP_W`/`TICK_W` defaults;
  - the hi/lo split constant 32.
- **Sub-module `asg_sweep_tick`:** loadable down-counter giving a one-cycle tick every period clocks. It has clear and load inputs and treats period 0 as 1.
- **Top level:** FSM, latched configuration, 65-bit add/sub with clamp, and output registers.

## Test plan
- **Linear single up:** mode 0, start=100, stop=130, delta=10, period=4, trigger at cycle 10 → `step_o` = 110/120/130 at cycles 15/19/23; `done_o` pulse at 23; `busy_o` low from 23; `sweep_cnt_o`=1.
- **Clamp and sawtooth:** mode 1, start=0, stop=25, delta=10, period=1 → sequence 10, 20, 25, 0, 10, …; `done_o` on each 25→0 wrap.
- **Triangle once, descending start:** mode 3, start=50, stop=20, delta=15 → sequence 35, 20, 35, 50, then DONE at 50; one `done_o`.
- **Overflow and simultaneous events:**
  - start=2^64−5, stop=2^64−1, delta=8 → a single clamp to 2^64−1, no wrap to a small value.
  - `set_rst_i` coincident with `trig_i` → IDLE, `step_o`=start, `busy_o` stays 0.
- **Geometric (macro defined):** set_log=1, shift=2, start=3, stop=20 → sequence 4, 5, 6, 7, 8, 10, 12, 15, 18, 20 (inc floor 1 applies from 3); with the macro undefined, the same stimulus runs the linear path.
- **Mid-sweep disable:** `set_en_i` dropped in FWD → IDLE next cycle; `step_o` held; a later trigger while ARMED restarts from start.

Source files
------------

// File: rtl/asg_sweep_pkg.sv
// -----------------------------------------------------------------------------
// asg_sweep_pkg
//   Shared definitions for the ASG frequency-sweep generator:
//     - swp_state_e : sweep FSM states
//     - swp_mode_e  : sweep mode encodings as seen on set_mode_i
//     - STEP_W_DEF / TICK_W_DEF : default step-word and tick-counter widths
//     - STEP_SPLIT  : bit position of the hi/lo split of the step word
//                     (step[63:32] -> set_step_i, step[31:0] -> set_step_lo_i)
// -----------------------------------------------------------------------------
package asg_sweep_pkg;

  localparam int unsigned STEP_W_DEF = 64;
  localparam int unsigned TICK_W_DEF = 32;
  localparam int unsigned STEP_SPLIT = 32;

  typedef enum logic [2:0] {
    SWP_IDLE  = 3'd0,
    SWP_ARMED = 3'd1,
    SWP_FWD   = 3'd2,
    SWP_REV   = 3'd3,
    SWP_DONE  = 3'd4
  } swp_state_e;

  typedef enum logic [1:0] {
    SWP_SINGLE   = 2'd0,  // one forward leg, then DONE
    SWP_SAW      = 2'd1,  // forward legs forever, jump back to start
    SWP_TRI      = 2'd2,  // forward/reverse legs forever
    SWP_TRI_ONCE = 2'd3   // one forward and one reverse leg, then DONE
  } swp_mode_e;

endpackage : asg_sweep_pkg

// File: rtl/red_pitaya_asg_sweep_tick.sv
// -----------------------------------------------------------------------------
// asg_sweep_tick
//   Loadable down-counter producing a one-cycle tick every `period` clocks.
//   A period of 0 behaves like 1 (tick every clock while running).
//
//   Ports:
//     clk_i     : clock
//     rst_i     : synchronous active-high reset
//     clr_i     : clear counter (highest priority after reset)
//     load_i    : capture period_i and load period-1 into the counter
//     run_i     : count while high; tick_o only asserted while running
//     period_i  : update period in clocks, sampled on load_i
//     tick_o    : one-cycle tick when the counter reaches zero
// -----------------------------------------------------------------------------
module asg_sweep_tick
  import asg_sweep_pkg::*;
#(
  parameter int unsigned TICK_W = TICK_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              run_i,
  input  logic [TICK_W-1:0] period_i,
  output logic              tick_o
);

  localparam logic [TICK_W-1:0] ONE = {{(TICK_W-1){1'b0}}, 1'b1};

  logic [TICK_W-1:0] period_q;
  logic [TICK_W-1:0] cnt_q;
  logic [TICK_W-1:0] load_val;
  logic [TICK_W-1:0] reload_val;

  // Zero period is folded to one, so both reload values saturate at zero.
  assign load_val   = (period_i == '0) ? '0 : period_i - ONE;
  assign reload_val = (period_q == '0) ? '0 : period_q - ONE;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      period_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      period_q <= period_i;
      cnt_q    <= load_val;
    end else if (run_i) begin
      if (cnt_q == '0) cnt_q <= reload_val;
      else             cnt_q <= cnt_q - ONE;
    end
  end

  assign tick_o = run_i && (cnt_q == '0);

endmodule : asg_sweep_tick

// File: rtl/red_pitaya_asg_sweep.sv
// -----------------------------------------------------------------------------
// red_pitaya_asg_sweep
//   Frequency-sweep generator for the ASG channel phase-step inputs. After a
//   trigger the 64-bit step word moves from start to stop in linear (or,
//   with ASG_SWEEP_LOG_EN defined, geometric) increments, once per update
//   period. Modes: single, sawtooth repeat, triangle repeat, triangle single.
//
//   Configuration macro: ASG_SWEEP_LOG_EN
//     defined   : set_log_i / set_log_shift_i select the geometric path
//     undefined : both inputs are ignored, the sweep is always linear
//
//   Ports:
//     dac_clk_i       : DAC clock
//     dac_rst_i       : synchronous active-high reset
//     trig_i          : start pulse (accepted only in ARMED)
//     set_en_i        : sweep enable, low forces IDLE with step_o held
//     set_rst_i       : soft reset to IDLE, reloads step_o from set_start_i
//     set_start_i     : start step word
//     set_stop_i      : stop step word
//     set_delta_i     : linear increment
//     set_period_i    : clocks between updates (0 treated as 1)
//     set_mode_i      : sweep mode (see swp_mode_e)
//     set_log_i       : geometric sweep select
//     set_log_shift_i : geometric ratio 2^-shift
//     step_o          : current step word ([63:32] hi, [31:0] lo)
//     step_vld_o      : one-cycle pulse aligned with a change of step_o
//     busy_o          : high while in FWD/REV
//     done_o          : one-cycle pulse per completed sweep
//     sweep_cnt_o     : completed sweep count, wraps at 2^32
// -----------------------------------------------------------------------------
module red_pitaya_asg_sweep
  import asg_sweep_pkg::*;
#(
  parameter int unsigned STEP_W = STEP_W_DEF,
  parameter int unsigned TICK_W = TICK_W_DEF
) (
  input  logic              dac_clk_i,
  input  logic              dac_rst_i,
  input  logic              trig_i,
  input  logic              set_en_i,
  input  logic              set_rst_i,
  input  logic [STEP_W-1:0] set_start_i,
  input  logic [STEP_W-1:0] set_stop_i,
  input  logic [STEP_W-1:0] set_delta_i,
  input  logic [TICK_W-1:0] set_period_i,
  input  logic [1:0]        set_mode_i,
  input  logic              set_log_i,
  input  logic [5:0]        set_log_shift_i,
  output logic [STEP_W-1:0] step_o,
  output logic              step_vld_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       sweep_cnt_o
);

  // ---------------------------------------------------------------------------
  // State and latched configuration
  // ---------------------------------------------------------------------------
  swp_state_e        state_q;
  swp_mode_e         mode_q;
  logic [STEP_W-1:0] start_q;
  logic [STEP_W-1:0] stop_q;
  logic [STEP_W-1:0] delta_q;
  logic              up_q;       // forward leg direction: 1 = increasing
  logic              wrap_q;     // sawtooth reached stop, jump to start next tick
  logic [STEP_W-1:0] step_q;
  logic              vld_q;
  logic              busy_q;
  logic              done_q;
  logic [31:0]       sweep_cnt_q;

  // ---------------------------------------------------------------------------
  // Update tick
  // ---------------------------------------------------------------------------
  logic tick;
  logic tick_clr;
  logic tick_load;
  logic tick_run;

  assign tick_clr  = set_rst_i || !set_en_i;
  assign tick_load = (state_q == SWP_ARMED) && trig_i;
  assign tick_run  = (state_q == SWP_FWD) || (state_q == SWP_REV);

  asg_sweep_tick #(
    .TICK_W (TICK_W)
  ) u_tick (
    .clk_i    (dac_clk_i),
    .rst_i    (dac_rst_i),
    .clr_i    (tick_clr),
    .load_i   (tick_load),
    .run_i    (tick_run),
    .period_i (set_period_i),
    .tick_o   (tick)
  );

  // ---------------------------------------------------------------------------
  // Increment selection
  // ---------------------------------------------------------------------------
  logic [STEP_W-1:0] inc;

`ifdef ASG_SWEEP_LOG_EN
  localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

  logic              log_q;
  logic [5:0]        shift_q;
  logic [STEP_W-1:0] geo_inc;

  // Geometric increment cur >> shift, floored at 1 so small values still move.
  always_comb begin
    geo_inc = step_q >> shift_q;
    if (geo_inc == '0) geo_inc = STEP_ONE;
    inc = log_q ? geo_inc : delta_q;
  end
`else
  logic unused_log_cfg;
  assign unused_log_cfg = ^{set_log_i, set_log_shift_i};
  assign inc            = delta_q;
`endif

  // ---------------------------------------------------------------------------
  // Leg arithmetic: one extra bit catches carry (up) or borrow (down); either
  // one, or passing the leg target, clamps the result to the target.
  // ---------------------------------------------------------------------------
  logic              leg_up;
  logic [STEP_W-1:0] leg_target;
  logic [STEP_W:0]   sum_w;
  logic [STEP_W:0]   dif_w;
  logic              leg_hit;
  logic [STEP_W-1:0] leg_nxt;

  // NOTE: every signal written here gets a value on every path through the
  // block, otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    leg_up     = (state_q == SWP_FWD) ? up_q : !up_q;
    leg_target = (state_q == SWP_FWD) ? stop_q : start_q;
    sum_w      = {1'b0, step_q} + {1'b0, inc};
    dif_w      = {1'b0, step_q} - {1'b0, inc};
    if (leg_up) begin
      leg_hit = sum_w[STEP_W] || (sum_w[STEP_W-1:0] >= leg_target);
      leg_nxt = leg_hit ? leg_target : sum_w[STEP_W-1:0];
    end else begin
      leg_hit = dif_w[STEP_W] || (dif_w[STEP_W-1:0] <= leg_target);
      leg_nxt = leg_hit ? leg_target : dif_w[STEP_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM with registered outputs. vld_q/done_q default low and are raised only
  // in the cycle whose edge changes step_q / completes a sweep.
  // ---------------------------------------------------------------------------
  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q     <= SWP_IDLE;
      mode_q      <= SWP_SINGLE;
      start_q     <= '0;
      stop_q      <= '0;
      delta_q     <= '0;
      up_q        <= 1'b0;
      wrap_q      <= 1'b0;
      step_q      <= '0;
      vld_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sweep_cnt_q <= '0;
`ifdef ASG_SWEEP_LOG_EN
      log_q       <= 1'b0;
      shift_q     <= '0;
`endif
    end else begin
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      if (set_rst_i) begin
        // Soft reset beats a coincident trigger: the trigger is simply lost.
        state_q <= SWP_IDLE;
        step_q  <= set_start_i;
        vld_q   <= (set_start_i != step_q);
        busy_q  <= 1'b0;
        wrap_q  <= 1'b0;
      end else if (!set_en_i) begin
        // Disable keeps the last step word on the output.
        state_q <= SWP_IDLE;
        busy_q  <= 1'b0;
        wrap_q  <= 1'b0;
      end else begin
        case (state_q)
          SWP_IDLE: begin
            state_q <= SWP_ARMED;
            step_q  <= set_start_i;
            vld_q   <= (set_start_i != step_q);
          end

          SWP_ARMED: begin
            if (trig_i) begin
              state_q <= SWP_FWD;
              busy_q  <= 1'b1;
              wrap_q  <= 1'b0;
              start_q <= set_start_i;
              stop_q  <= set_stop_i;
              delta_q <= set_delta_i;
              mode_q  <= swp_mode_e'(set_mode_i);
              up_q    <= (set_start_i < set_stop_i);
              step_q  <= set_start_i;
              vld_q   <= (set_start_i != step_q);
`ifdef ASG_SWEEP_LOG_EN
              log_q   <= set_log_i;
              shift_q <= set_log_shift_i;
`endif
            end
          end

          SWP_FWD: begin
            if (tick) begin
              if (wrap_q) begin
                // Sawtooth wrap: the stop value was held for one period.
                wrap_q      <= 1'b0;
                step_q      <= start_q;
                vld_q       <= (start_q != step_q);
                done_q      <= 1'b1;
                sweep_cnt_q <= sweep_cnt_q + 32'd1;
              end else begin
                step_q <= leg_nxt;
                vld_q  <= (leg_nxt != step_q);
                if (leg_hit) begin
                  case (mode_q)
                    SWP_SINGLE: begin
                      state_q     <= SWP_DONE;
                      busy_q      <= 1'b0;
                      done_q      <= 1'b1;
                      sweep_cnt_q <= sweep_cnt_q + 32'd1;
                    end
                    SWP_SAW: wrap_q  <= 1'b1;
                    default: state_q <= SWP_REV;
                  endcase
                end
              end
            end
          end

          SWP_REV: begin
            if (tick) begin
              step_q <= leg_nxt;
              vld_q  <= (leg_nxt != step_q);
              if (leg_hit) begin
                done_q      <= 1'b1;
                sweep_cnt_q <= sweep_cnt_q + 32'd1;
                if (mode_q == SWP_TRI) begin
                  state_q <= SWP_FWD;
                end else begin
                  state_q <= SWP_DONE;
                  busy_q  <= 1'b0;
                end
              end
            end
          end

          SWP_DONE: begin
            // Hold until disabled or soft-reset; triggers are ignored.
          end

          default: begin
            state_q <= SWP_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: the hi half feeds set_step_i, the lo half feeds set_step_lo_i.
  // ---------------------------------------------------------------------------
  assign step_o      = {step_q[STEP_W-1:STEP_SPLIT], step_q[STEP_SPLIT-1:0]};
  assign step_vld_o  = vld_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign sweep_cnt_o = sweep_cnt_q;

endmodule : red_pitaya_asg_sweep

// File: tb/tb_red_pitaya_asg_sweep.sv
// -----------------------------------------------------------------------------
// tb_red_pitaya_asg_sweep
//   Self-checking bench for red_pitaya_asg_sweep. A reference model turns the
//   sweep rules into the expected list of step-word events (one per update
//   tick); the bench replays that list against the DUT cycle by cycle.
//   Honours ASG_SWEEP_LOG_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_red_pitaya_asg_sweep;

`ifdef ASG_SWEEP_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  localparam logic [63:0] MAX64 = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [63:0] val;
    bit          done;
    bit          last;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig_i = 1'b0;
  logic        set_en_i = 1'b0;
  logic        set_rst_i = 1'b0;
  logic [63:0] set_start_i = '0;
  logic [63:0] set_stop_i = '0;
  logic [63:0] set_delta_i = '0;
  logic [31:0] set_period_i = '0;
  logic [1:0]  set_mode_i = '0;
  logic        set_log_i = 1'b0;
  logic [5:0]  set_log_shift_i = '0;
  logic [63:0] step_o;
  logic        step_vld_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] sweep_cnt_o;

  int          vectors = 0;
  int          miscompares = 0;
  ev_t         evq[$];
  logic [63:0] prev_step = '0;
  logic [31:0] exp_cnt = '0;

  red_pitaya_asg_sweep dut (
    .dac_clk_i       (clk),
    .dac_rst_i       (rst),
    .trig_i          (trig_i),
    .set_en_i        (set_en_i),
    .set_rst_i       (set_rst_i),
    .set_start_i     (set_start_i),
    .set_stop_i      (set_stop_i),
    .set_delta_i     (set_delta_i),
    .set_period_i    (set_period_i),
    .set_mode_i      (set_mode_i),
    .set_log_i       (set_log_i),
    .set_log_shift_i (set_log_shift_i),
    .step_o          (step_o),
    .step_vld_o      (step_vld_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .sweep_cnt_o     (sweep_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Expected step-word events of one sweep, one entry per update tick.
  task automatic gen_events(input logic [63:0] s, input logic [63:0] t,
                            input logic [63:0] d, input bit lg, input int sh,
                            input logic [1:0] m, input int max_ev);
    logic [63:0] cur, goal, inc;
    bit          up, rev, wrap, going_up, reached, geo;
    ev_t         ev;
    cur = s;
    up  = (s < t);
    rev = 1'b0;
    wrap = 1'b0;
    geo = lg && LOG_EN;
    evq.delete();
    while (evq.size() < max_ev) begin
      ev.done = 1'b0;
      ev.last = 1'b0;
      if (wrap) begin
        cur = s;
        wrap = 1'b0;
        ev.done = 1'b1;
      end else begin
        goal     = rev ? s : t;
        going_up = rev ? !up : up;
        inc      = geo ? (cur >> sh) : d;
        if (geo && inc == 0) inc = 64'd1;
        if (going_up) reached = (inc > (MAX64 - cur)) || (cur + inc >= goal);
        else          reached = (inc > cur) || (cur - inc <= goal);
        if (reached)       cur = goal;
        else if (going_up) cur = cur + inc;
        else               cur = cur - inc;
        if (reached) begin
          if (!rev) begin
            if (m == 2'd0) begin ev.done = 1'b1; ev.last = 1'b1; end
            else if (m == 2'd1) wrap = 1'b1;
            else rev = 1'b1;
          end else begin
            ev.done = 1'b1;
            if (m == 2'd3) ev.last = 1'b1;
            else rev = 1'b0;
          end
        end
      end
      ev.val = cur;
      evq.push_back(ev);
      if (ev.last) break;
    end
  endtask

  // Arm, trigger, replay the expected events, then disable. Entered at a
  // negedge with the DUT in IDLE. With noisy set, the set_* inputs and
  // trig_i are scrambled during the sweep to prove they are latched/ignored.
  task automatic run_sweep(input string name, input logic [63:0] s, input logic [63:0] t,
                           input logic [63:0] d, input logic [31:0] p, input logic [1:0] m,
                           input bit lg, input logic [5:0] sh, input int max_ev, input bit noisy);
    int  peff, n, last_e;
    bit  ends, fin;
    ev_t ev;
    logic exp_vld, exp_done;
    set_start_i = s; set_stop_i = t; set_delta_i = d; set_period_i = p;
    set_mode_i = m; set_log_i = lg; set_log_shift_i = sh;
    set_en_i = 1'b1; trig_i = 1'b0;
    @(negedge clk);
    check({name, "_arm_step"}, step_o, s);
    check({name, "_arm_vld"}, step_vld_o, (s != prev_step));
    check({name, "_arm_busy"}, busy_o, 1'b0);
    prev_step = s;
    trig_i = 1'b1;
    @(negedge clk);
    trig_i = 1'b0;
    check({name, "_trig_busy"}, busy_o, 1'b1);
    check({name, "_trig_step"}, step_o, s);
    check({name, "_trig_vld"}, step_vld_o, 1'b0);

    gen_events(s, t, d, lg, int'(sh), m, max_ev);
    peff   = (p == 0) ? 1 : int'(p);
    n      = evq.size();
    ends   = evq[n-1].last;
    last_e = n * peff + (ends ? peff + 2 : 0);
    fin    = 1'b0;
    for (int e = 1; e <= last_e; e++) begin
      if (noisy) begin
        set_start_i = rand64(); set_stop_i = rand64(); set_delta_i = rand64();
        set_period_i = $urandom_range(0, 7); set_mode_i = 2'($urandom_range(0, 3));
        set_log_i = 1'($urandom_range(0, 1)); set_log_shift_i = 6'($urandom_range(0, 63));
        trig_i = ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
      exp_vld  = 1'b0;
      exp_done = 1'b0;
      if ((e % peff) == 0 && evq.size() > 0) begin
        ev = evq.pop_front();
        exp_vld  = (ev.val != prev_step);
        exp_done = ev.done;
        prev_step = ev.val;
        if (ev.done) exp_cnt = exp_cnt + 32'd1;
        if (ev.last) fin = 1'b1;
      end
      check({name, "_step"}, step_o, prev_step);
      check({name, "_vld"}, step_vld_o, exp_vld);
      check({name, "_done"}, done_o, exp_done);
      check({name, "_busy"}, busy_o, !fin);
      check({name, "_cnt"}, sweep_cnt_o, exp_cnt);
    end
    trig_i = 1'b0;
    set_en_i = 1'b0;
    @(negedge clk);
    check({name, "_dis_busy"}, busy_o, 1'b0);
    check({name, "_dis_step"}, step_o, prev_step);
    check({name, "_dis_vld"}, step_vld_o, 1'b0);
    check({name, "_dis_done"}, done_o, 1'b0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_step", step_o, 64'd0);
    check("rst_vld", step_vld_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_cnt", sweep_cnt_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy_o, 1'b0);

    // Linear single up: 110/120/130 every 4 clocks, one completed sweep.
    run_sweep("lin_up", 64'd100, 64'd130, 64'd10, 32'd4, 2'd0, 1'b0, 6'd0, 10, 1'b0);
    check("lin_up_final", step_o, 64'd130);
    check("lin_up_count", sweep_cnt_o, 32'd1);

    // Clamp and sawtooth: 10, 20, 25, 0, 10, ...
    run_sweep("saw", 64'd0, 64'd25, 64'd10, 32'd1, 2'd1, 1'b0, 6'd0, 9, 1'b0);

    // Triangle once, descending start: 35, 20, 35, 50, DONE.
    run_sweep("tri1", 64'd50, 64'd20, 64'd15, 32'd2, 2'd3, 1'b0, 6'd0, 10, 1'b0);

    // Triangle repeat, ascending.
    run_sweep("tri", 64'd5, 64'd40, 64'd12, 32'd3, 2'd2, 1'b0, 6'd0, 12, 1'b0);

    // Overflow: the carry clamps to 2^64-1 instead of wrapping.
    run_sweep("ovf", MAX64 - 64'd4, MAX64, 64'd8, 32'd3, 2'd0, 1'b0, 6'd0, 4, 1'b0);
    check("ovf_final", step_o, MAX64);

    // Degenerate: start == stop, and zero delta never finishing.
    run_sweep("same", 64'd77, 64'd77, 64'd5, 32'd2, 2'd0, 1'b0, 6'd0, 4, 1'b0);
    run_sweep("zdelta", 64'd10, 64'd90, 64'd0, 32'd1, 2'd0, 1'b0, 6'd0, 6, 1'b0);

    // Geometric (linear with delta 1 when the feature is not built).
    run_sweep("geo", 64'd3, 64'd20, 64'd1, 32'd1, 2'd0, 1'b1, 6'd2, 24, 1'b0);

    // Period 0 behaves as 1.
    run_sweep("p0", 64'd200, 64'd150, 64'd7, 32'd0, 2'd0, 1'b0, 6'd0, 12, 1'b0);

    // Mid-sweep disable, then a fresh trigger restarts from start.
    run_sweep("mid1", 64'd0, 64'd1000, 64'd10, 32'd2, 2'd0, 1'b0, 6'd0, 5, 1'b0);
    run_sweep("mid2", 64'd0, 64'd1000, 64'd10, 32'd2, 2'd0, 1'b0, 6'd0, 3, 1'b0);

    // Soft reset coincident with trigger: IDLE, step reloads, trigger lost.
    set_start_i = 64'd77;
    set_en_i = 1'b1;
    @(negedge clk);
    check("srst_arm_step", step_o, 64'd77);
    set_start_i = 64'd88;
    set_rst_i = 1'b1;
    trig_i = 1'b1;
    @(negedge clk);
    set_rst_i = 1'b0;
    trig_i = 1'b0;
    check("srst_step", step_o, 64'd88);
    check("srst_vld", step_vld_o, 1'b1);
    check("srst_busy", busy_o, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("srst_busy_hold", busy_o, 1'b0);
      check("srst_step_hold", step_o, 64'd88);
    end
    set_en_i = 1'b0;
    @(negedge clk);
    prev_step = 64'd88;

    // Randomized sweeps with input noise during the sweep.
    for (int r = 0; r < 25; r++) begin
      logic [63:0] s, t, d;
      if ($urandom_range(0, 5) == 0) begin
        s = MAX64 - 64'($urandom_range(0, 60));
        t = MAX64 - 64'($urandom_range(0, 60));
      end else begin
        s = 64'($urandom_range(0, 300));
        t = 64'($urandom_range(0, 300));
      end
      d = 64'($urandom_range(1, 40));
      run_sweep("rnd", s, t, d, 32'($urandom_range(0, 4)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 6'($urandom_range(0, 3)),
                $urandom_range(3, 25), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_red_pitaya_asg_sweep
